// File: rtl/bitbakery_serial_rx.sv
// bitbakery_serial_rx
// 8E1 serial receiver for BitBakery. It oversamples the serial line, recovers
// each 8-bit character LSB first, and checks the parity and stop bits. Good
// bytes go into a 4-entry FIFO that the consumer drains with a read strobe.
//
// Optional feature macro: BITBAKERY_RX_PARITY_CHECK_EN
//   defined   - bytes with a parity mismatch are dropped and erro_paridade pulses
//   undefined - the parity bit is sampled but ignored; erro_paridade is tied to 0
//
// Parameters:
//   CLKS_PER_BIT   clock cycles per serial bit (>= 4)
// Ports:
//   clock          single clock, rising edge
//   reset          synchronous, active-high
//   entrada_serial asynchronous serial line, idle high
//   dado_lido      pop strobe, ignored while the FIFO is empty
//   dado_recebido  FIFO head byte, 0x00 when empty
//   tem_dado       FIFO not empty
//   erro_paridade  1-cycle pulse, parity mismatch
//   erro_stop      1-cycle pulse, stop bit sampled 0
//   estouro        1-cycle pulse, good byte dropped because the FIFO is full
//   recebendo      high while a frame is being received (FSM outside idle)
module bitbakery_serial_rx #(
   parameter int unsigned CLKS_PER_BIT = 434
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       entrada_serial,
   input  logic       dado_lido,
   output logic [7:0] dado_recebido,
   output logic       tem_dado,
   output logic       erro_paridade,
   output logic       erro_stop,
   output logic       estouro,
   output logic       recebendo
);

   localparam int unsigned CntW = $clog2(CLKS_PER_BIT + 1);
   localparam logic [CntW-1:0] CntFull = CntW'(CLKS_PER_BIT);
   localparam logic [CntW-1:0] CntHalf = CntW'(CLKS_PER_BIT / 2);
   localparam logic [CntW-1:0] CntOne  = CntW'(1);

   typedef enum logic [2:0] {
      StIdle, StStart, StData, StParity, StStop, StWaitIdle
   } state_e;

   state_e          state_q, state_d;
   logic [1:0]      sync_q;
   logic            rx_s;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [2:0]      idx_q, idx_d;
   logic [7:0]      shift_q, shift_d;
   logic            tick;
   logic            push;
   logic            stop_err_d, stop_err_q;
   logic            ovf_d, ovf_q;

   // FIFO state
   logic [7:0] mem_q [4];
   logic [1:0] wr_ptr_q, rd_ptr_q;
   logic [2:0] count_q, count_d;
   logic       pop, wr, full;

   assign rx_s = sync_q[1];
   // Counter holds the cycles left to the next sample point; 1 means sample now.
   assign tick = (cnt_q == CntOne);

`ifdef BITBAKERY_RX_PARITY_CHECK_EN
   logic par_ok_q, par_ok_d;
   logic par_err_d, par_err_q;
`endif

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      idx_d      = idx_q;
      shift_d    = shift_q;
      push       = 1'b0;
      stop_err_d = 1'b0;
`ifdef BITBAKERY_RX_PARITY_CHECK_EN
      par_ok_d   = par_ok_q;
      par_err_d  = 1'b0;
`endif
      if (state_q != StIdle && state_q != StWaitIdle) begin
         cnt_d = tick ? CntFull : cnt_q - CntOne;
      end
      unique case (state_q)
         StIdle: begin
            if (!rx_s) begin
               cnt_d   = CntHalf;
               state_d = StStart;
            end
         end
         StStart: begin
            if (tick) begin
               if (rx_s) begin
                  state_d = StIdle;  // glitch shorter than half a bit
               end else begin
                  idx_d   = 3'd0;
                  state_d = StData;
               end
            end
         end
         StData: begin
            if (tick) begin
               shift_d = {rx_s, shift_q[7:1]};
               if (idx_q == 3'd7) state_d = StParity;
               else idx_d = idx_q + 3'd1;
            end
         end
         StParity: begin
            if (tick) begin
`ifdef BITBAKERY_RX_PARITY_CHECK_EN
               par_ok_d = (rx_s == ^shift_q);
`endif
               state_d = StStop;
            end
         end
         StStop: begin
            if (tick) begin
               if (!rx_s) begin
                  stop_err_d = 1'b1;
                  state_d    = StWaitIdle;
`ifdef BITBAKERY_RX_PARITY_CHECK_EN
               end else if (!par_ok_q) begin
                  par_err_d = 1'b1;
                  state_d   = StIdle;
`endif
               end else begin
                  push    = 1'b1;
                  state_d = StIdle;
               end
            end
         end
         StWaitIdle: begin
            // A held-low line (break) must not restart reception.
            if (rx_s) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // FIFO control: a pop frees a slot in the same cycle, so push+pop when full succeeds.
   assign pop   = dado_lido && (count_q != 3'd0);
   assign full  = (count_q == 3'd4);
   assign wr    = push && (!full || pop);
   assign ovf_d = push && full && !pop;

   always_comb begin
      count_d = count_q;
      unique case ({wr, pop})
         2'b10:   count_d = count_q + 3'd1;
         2'b01:   count_d = count_q - 3'd1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         sync_q     <= 2'b11;
         state_q    <= StIdle;
         cnt_q      <= '0;
         idx_q      <= '0;
         shift_q    <= '0;
         stop_err_q <= 1'b0;
         ovf_q      <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         sync_q     <= {sync_q[0], entrada_serial};
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         shift_q    <= shift_d;
         stop_err_q <= stop_err_d;
         ovf_q      <= ovf_d;
         if (wr)  wr_ptr_q <= wr_ptr_q + 2'd1;
         if (pop) rd_ptr_q <= rd_ptr_q + 2'd1;
         count_q    <= count_d;
      end
   end

   always_ff @(posedge clock) begin
      if (wr) mem_q[wr_ptr_q] <= shift_q;
   end

`ifdef BITBAKERY_RX_PARITY_CHECK_EN
   always_ff @(posedge clock) begin
      if (reset) begin
         par_ok_q  <= 1'b1;
         par_err_q <= 1'b0;
      end else begin
         par_ok_q  <= par_ok_d;
         par_err_q <= par_err_d;
      end
   end
   assign erro_paridade = par_err_q;
`else
   assign erro_paridade = 1'b0;
`endif

   assign tem_dado      = (count_q != 3'd0);
   assign dado_recebido = tem_dado ? mem_q[rd_ptr_q] : 8'h00;
   assign erro_stop     = stop_err_q;
   assign estouro       = ovf_q;
   assign recebendo     = (state_q != StIdle);

endmodule

// File: tb/tb_bitbakery_serial_rx.sv
// Bench for bitbakery_serial_rx: directed frames plus randomized frames,
// checked against a queue-based model of the receive rules.
module tb_bitbakery_serial_rx;

   localparam int unsigned C = 8;
`ifdef BITBAKERY_RX_PARITY_CHECK_EN
   localparam bit ParChk = 1'b1;
`else
   localparam bit ParChk = 1'b0;
`endif

   logic       clock = 1'b0;
   logic       reset;
   logic       entrada_serial;
   logic       dado_lido;
   logic [7:0] dado_recebido;
   logic       tem_dado;
   logic       erro_paridade;
   logic       erro_stop;
   logic       estouro;
   logic       recebendo;

   always #5 clock = ~clock;

   bitbakery_serial_rx #(.CLKS_PER_BIT(C)) dut (
      .clock          (clock),
      .reset          (reset),
      .entrada_serial (entrada_serial),
      .dado_lido      (dado_lido),
      .dado_recebido  (dado_recebido),
      .tem_dado       (tem_dado),
      .erro_paridade  (erro_paridade),
      .erro_stop      (erro_stop),
      .estouro        (estouro),
      .recebendo      (recebendo)
   );

   int errors = 0;
   int checks = 0;

   byte unsigned model_q[$];
   int e_perr = 0, e_serr = 0, e_ovf = 0;
   int n_perr = 0, n_serr = 0, n_ovf = 0;

   // Pulse counters: a pulse longer than one cycle over-counts.
   always @(negedge clock) begin
      if (erro_paridade === 1'b1) n_perr++;
      if (erro_stop === 1'b1)     n_serr++;
      if (estouro === 1'b1)       n_ovf++;
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   // Drives bits[0..n-1], one bit period each; leaves the line at the last bit.
   task automatic send_bits(input logic [10:0] bits, input int n);
      for (int i = 0; i < n; i++) begin
         entrada_serial = bits[i];
         tick(C);
      end
   endtask

   function automatic logic [10:0] make_frame(input logic [7:0] d, input bit bad_par,
                                              input bit stop_val);
      return {stop_val, (^d) ^ bad_par, d, 1'b0};
   endfunction

   // Expected outcome of one complete frame.
   task automatic model_frame(input logic [7:0] d, input bit bad_par, input bit stop_val,
                              input bit popped);
      if (popped && model_q.size() > 0) void'(model_q.pop_front());
      if (!stop_val) e_serr++;
      else if (ParChk && bad_par) e_perr++;
      else if (model_q.size() == 4) e_ovf++;
      else model_q.push_back(d);
   endtask

   task automatic check_fifo(input string tag);
      check_val({tag, "/tem_dado"}, 32'(tem_dado), 32'(model_q.size() != 0));
      check_val({tag, "/dado"}, 32'(dado_recebido),
                (model_q.size() != 0) ? 32'(model_q[0]) : 32'h0);
      check_val({tag, "/erro_paridade_cnt"}, n_perr, e_perr);
      check_val({tag, "/erro_stop_cnt"}, n_serr, e_serr);
      check_val({tag, "/estouro_cnt"}, n_ovf, e_ovf);
   endtask

   task automatic pop_one();
      dado_lido = 1'b1;
      tick(1);
      dado_lido = 1'b0;
      if (model_q.size() > 0) void'(model_q.pop_front());
   endtask

   task automatic frame(input string tag, input logic [7:0] d, input bit bad_par,
                        input bit stop_val);
      send_bits(make_frame(d, bad_par, stop_val), 11);
      model_frame(d, bad_par, stop_val, 1'b0);
      if (!stop_val) begin
         tick(int'($urandom_range(1, 20)));
         entrada_serial = 1'b1;
      end
      tick(4);
      check_fifo(tag);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [10:0] f;
      reset          = 1'b1;
      entrada_serial = 1'b1;
      dado_lido      = 1'b0;
      tick(2);
      check_val("reset/dado", 32'(dado_recebido), 32'h0);
      check_val("reset/flags", 32'({tem_dado, erro_paridade, erro_stop, estouro, recebendo}),
                32'h0);
      reset = 1'b0;
      tick(3);

      // 0xA5: push lands exactly at the stop-sample edge (frame start + 87 cycles).
      f = make_frame(8'hA5, 1'b0, 1'b1);
      send_bits(f, 10);
      entrada_serial = 1'b1;
      tick(6);
      check_val("a5/before_stop_sample", 32'(tem_dado), 32'h0);
      tick(1);
      model_frame(8'hA5, 1'b0, 1'b1, 1'b0);
      check_fifo("a5/after_stop_sample");
      tick(4);
      pop_one();
      check_fifo("a5/popped");
      pop_one();  // pop while empty: no effect
      check_fifo("a5/pop_empty");

      // 0x03 with parity bit flipped
      frame("par03", 8'h03, 1'b1, 1'b1);
      while (model_q.size() > 0) pop_one();
      check_fifo("par03/drained");

      // Stop error, break held low, then a good byte
      send_bits(make_frame(8'h5A, 1'b0, 1'b0), 11);
      model_frame(8'h5A, 1'b0, 1'b0, 1'b0);
      tick(30);
      entrada_serial = 1'b1;
      tick(6);
      frame("brk11", 8'h11, 1'b0, 1'b1);
      pop_one();
      check_fifo("brk11/drained");

      // Overflow: five bytes, no reads
      for (int i = 1; i <= 5; i++) frame($sformatf("ovf%0d", i), 8'(i), 1'b0, 1'b1);
      check_val("ovf/estouro_once", n_ovf, 1);
      for (int i = 1; i <= 4; i++) begin
         check_val($sformatf("ovf/order%0d", i), 32'(dado_recebido), i);
         pop_one();
      end
      check_fifo("ovf/empty");

      // Full FIFO, push and pop on the same edge: no overflow, count stays 4
      for (int i = 0; i < 4; i++) frame("fill", 8'h20 + 8'(i), 1'b0, 1'b1);
      fork
         send_bits(make_frame(8'h99, 1'b0, 1'b1), 11);
         begin
            tick(86);
            dado_lido = 1'b1;
            tick(1);
            dado_lido = 1'b0;
         end
      join
      model_frame(8'h99, 1'b0, 1'b1, 1'b1);
      tick(4);
      check_fifo("pushpop_full");
      check_val("pushpop_full/size", model_q.size(), 4);
      while (model_q.size() > 0) pop_one();
      check_fifo("pushpop_full/drained");

      // Short low glitch
      entrada_serial = 1'b0;
      tick(3);
      entrada_serial = 1'b1;
      tick(2);
      check_val("glitch/recebendo_high", 32'(recebendo), 32'h1);
      tick(8);
      check_val("glitch/recebendo_low", 32'(recebendo), 32'h0);
      check_fifo("glitch");

      // Reset during data bit 4, with a byte already queued
      frame("prereset", 8'h33, 1'b0, 1'b1);
      f = make_frame(8'hC9, 1'b0, 1'b1);
      send_bits(f, 5);
      entrada_serial = f[5];
      tick(2);
      reset          = 1'b1;
      entrada_serial = 1'b1;
      tick(1);
      check_val("midreset/dado", 32'(dado_recebido), 32'h0);
      check_val("midreset/flags",
                32'({tem_dado, erro_paridade, erro_stop, estouro, recebendo}), 32'h0);
      reset = 1'b0;
      model_q.delete();
      tick(4);
      frame("postreset7e", 8'h7E, 1'b0, 1'b1);
      check_val("postreset/size", model_q.size(), 1);
      pop_one();

      // Randomized frames with random errors and reads
      for (int n = 0; n < 40; n++) begin
         logic [7:0] d;
         bit bp, sv;
         int pops;
         d  = 8'($urandom);
         bp = ($urandom_range(0, 3) == 0);
         sv = ($urandom_range(0, 5) != 0);
         frame($sformatf("rnd%0d", n), d, bp, sv);
         pops = int'($urandom_range(0, 2));
         for (int k = 0; k < pops; k++) pop_one();
         tick(int'($urandom_range(0, 3)));
         check_fifo($sformatf("rnd%0d/pop", n));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
